// File: rtl/nios_onchip_memory_pipelined.sv
// Parametrised single-port on-chip RAM behind an Avalon-MM pipelined slave with 1- or 2-cycle read latency.
// Define NIOS_ONCHIP_MEM_ZEROFILL_EN to build the post-reset zero-fill engine.
module nios_onchip_memory_pipelined #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 10,
    parameter int    DEPTH        = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "nios_onchip_memory2_0.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    input  logic                    reset_req,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    init_done
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_FILL,
        ST_READY
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  acc;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  fill_we;
    logic                  fill_last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  valid_q;

    assign init_done   = (state == ST_READY);
    assign waitrequest = reset | ~init_done;
    assign in_range    = ({1'b0, address} < DEPTH_W);
    assign acc         = chipselect & (read | write) & ~waitrequest & clken & ~reset_req;
    assign wr_acc      = acc & write;
    assign rd_acc      = acc & read & ~write;

`ifdef NIOS_ONCHIP_MEM_ZEROFILL_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    logic [ADDR_WIDTH-1:0] fill_addr;

    // Address 0 is already cleared on the first enabled edge after release, so the fill spans DEPTH cycles.
    assign fill_we   = clken & ~reset & (state != ST_READY);
    assign fill_last = (fill_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_addr <= '0;
        end else if (fill_we) begin
            fill_addr <= fill_addr + 1'b1;
        end
    end
`else
    assign fill_we   = 1'b0;
    assign fill_last = 1'b1;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = fill_last ? ST_READY : ST_FILL;
            ST_FILL:  if (fill_last) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RESET;
        end else if (clken) begin
            state <= state_next;
        end
    end

    always_comb begin
        mem_we    = wr_acc & in_range;
        mem_addr  = address;
        mem_wdata = writedata;
        mem_be    = byteenable;
`ifdef NIOS_ONCHIP_MEM_ZEROFILL_EN
        if (fill_we) begin
            mem_we    = 1'b1;
            mem_addr  = fill_addr;
            mem_wdata = '0;
            mem_be    = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clken) begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= in_range ? mem[address] : '0;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  out_valid;
        logic [DATA_WIDTH-1:0] out_data;

        always_ff @(posedge clk) begin
            if (reset) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else if (clken) begin
                out_valid <= rd_valid;
                if (rd_valid) begin
                    out_data <= rd_data;
                end
            end
        end

        assign valid_q  = out_valid;
        assign readdata = out_data;
    end else begin : g_lat1
        assign valid_q  = rd_valid;
        assign readdata = rd_data;
    end

    // Gating by clken means a held valid bit is presented exactly once, on the next enabled cycle.
    assign readdatavalid = valid_q & clken;

endmodule

// File: tb/tb_nios_onchip_memory_pipelined.sv
// Bench for nios_onchip_memory_pipelined: two instances (latency 1 / DEPTH 1000, latency 2 / DEPTH 16)
// driven with the same bus stimulus and checked every cycle against a transaction-level model.
module tb_nios_onchip_memory_pipelined;

    logic        clk = 1'b0;
    logic        reset, chipselect, read, write, clken, reset_req;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [1:0]  waitrequest, readdatavalid, init_done;
    logic [31:0] readdata [2];

    always #5 clk = ~clk;

    nios_onchip_memory_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(1), .INIT_FILE("")
    ) u_rl1 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .waitrequest(waitrequest[0]),
        .readdata(readdata[0]), .readdatavalid(readdatavalid[0]), .init_done(init_done[0])
    );

    nios_onchip_memory_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(16), .READ_LATENCY(2), .INIT_FILE("")
    ) u_rl2 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .waitrequest(waitrequest[1]),
        .readdata(readdata[1]), .readdatavalid(readdatavalid[1]), .init_done(init_done[1])
    );

`ifdef NIOS_ONCHIP_MEM_ZEROFILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          cnt;
    } pend_t;

    pend_t       pq [2][$];
    logic [31:0] mdl [2][1024];
    logic [31:0] last_rd [2];
    int          rc [2];
    logic [1:0]  exp_valid, exp_wait, exp_done, dchk, obs_valid, obs_wait, obs_done;
    logic [31:0] exp_data [2], obs_data [2];
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic int dep(input int k);
        return (k == 0) ? 1000 : 16;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int need(input int k);
        return FILL ? dep(k) : 1;
    endfunction

    // One clock: snapshot expectations and outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic [31:0] mask;
        pend_t       p;
        logic        acc;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_done[k]  = (rc[k] >= need(k));
            exp_wait[k]  = reset || !exp_done[k];
            exp_valid[k] = clken && pq[k].size() > 0 && pq[k][0].cnt == 0;
            exp_data[k]  = exp_valid[k] ? pq[k][0].data : last_rd[k];
            dchk[k]      = exp_valid[k] || pq[k].size() == 0;
            obs_data[k]  = readdata[k];
        end
        obs_valid = readdatavalid;
        obs_wait  = waitrequest;
        obs_done  = init_done;
        @(posedge clk);
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{byteenable[b]}};
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                pq[k].delete();
                last_rd[k] = '0;
                rc[k] = 0;
                if (FILL) for (int a = 0; a < 1024; a++) mdl[k][a] = '0;
            end else if (clken) begin
                acc = chipselect && (read || write) && !exp_wait[k] && !reset_req;
                if (exp_valid[k]) begin
                    last_rd[k] = pq[k][0].data;
                    void'(pq[k].pop_front());
                end
                for (int i = 0; i < pq[k].size(); i++) begin
                    p = pq[k][i];
                    if (p.cnt > 0) p.cnt = p.cnt - 1;
                    pq[k][i] = p;
                end
                if (acc && write) begin
                    if (int'(address) < dep(k))
                        mdl[k][address] = (mdl[k][address] & ~mask) | (writedata & mask);
                end else if (acc && read) begin
                    p.data = (int'(address) < dep(k)) ? mdl[k][address] : 32'h0;
                    p.cnt  = lat(k) - 1;
                    pq[k].push_back(p);
                end
                if (rc[k] < need(k)) rc[k] = rc[k] + 1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic cs, input logic rd, input logic wr, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        chipselect = cs; read = rd; write = wr; address = a; byteenable = be; writedata = wd;
    endtask

    task automatic test_reset();
        int wcnt [2];
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        drive(0, 0, 0, '0, '0, '0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL reset_hold: valid/wait/done got %b/%b/%b want %b/%b/%b", obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs_data[k] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_readdata[%0d]: got %h want 0", k, obs_data[k]);
                end
            end
        end
        reset = 1'b0;
        wcnt = '{0, 0};
        for (int i = 0; i < 1100; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) if (obs_wait[k]) wcnt[k]++;
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL init_seq: valid/wait/done got %b/%b/%b want %b/%b/%b", obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            if (obs_done == 2'b11 && exp_done == 2'b11) break;
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (wcnt[k] != need(k)) begin
                n_fail++;
                $display("FAIL init_wait_cycles[%0d]: got %0d want %0d", k, wcnt[k], need(k));
            end
        end
    endtask

    task automatic test_write_bytes();
        int          first [2];
        logic [31:0] got [2];
        first = '{-1, -1};
        got   = '{32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       drive(1, 0, 1, 10'd3, 4'b1111, 32'hDEADBEEF);
                1:       drive(1, 0, 1, 10'd3, 4'b0001, 32'h000000AA);
                2:       drive(1, 1, 0, 10'd3, 4'b0000, 32'h0);
                default: drive(0, 0, 0, 10'd0, 4'b0000, 32'h0);
            endcase
            cycle();
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL write_bytes_ctl: valid/wait/done got %b/%b/%b want %b/%b/%b", obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            for (int k = 0; k < 2; k++) begin
                if (dchk[k]) begin
                    n_tests++;
                    if (obs_data[k] !== exp_data[k]) begin
                        n_fail++;
                        $display("FAIL write_bytes_data[%0d]: got %h want %h", k, obs_data[k], exp_data[k]);
                    end
                end
                if (i >= 3 && obs_valid[k] && first[k] < 0) begin
                    first[k] = i - 2;
                    got[k]   = obs_data[k];
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (first[k] != lat(k) || got[k] !== 32'hDEADBEAA) begin
                n_fail++;
                $display("FAIL write_bytes_latency[%0d]: got cycle %0d data %h want cycle %0d data deadbeaa", k, first[k], got[k], lat(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen [2][$];
        for (int i = 0; i < 14; i++) begin
            if (i < 4)      drive(1, 0, 1, 10'(i), 4'b1111, 32'h10 + 32'(i));
            else if (i < 8) drive(1, 1, 0, 10'(i - 4), 4'b0000, 32'h0);
            else            drive(0, 0, 0, 10'd0, 4'b0000, 32'h0);
            cycle();
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL b2b_ctl: valid/wait/done got %b/%b/%b want %b/%b/%b", obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            for (int k = 0; k < 2; k++) begin
                if (dchk[k]) begin
                    n_tests++;
                    if (obs_data[k] !== exp_data[k]) begin
                        n_fail++;
                        $display("FAIL b2b_data[%0d]: got %h want %h", k, obs_data[k], exp_data[k]);
                    end
                end
                if (obs_valid[k]) seen[k].push_back(obs_data[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (seen[k].size() != 4 || seen[k][0] !== 32'h10 || seen[k][1] !== 32'h11 ||
                seen[k][2] !== 32'h12 || seen[k][3] !== 32'h13) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got %0d pulses, want 4 pulses 10,11,12,13", k, seen[k].size());
            end
        end
    endtask

    task automatic test_clken();
        int          pulses [2];
        logic [31:0] got [2];
        pulses = '{0, 0};
        got    = '{32'h0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            clken = !(i >= 2 && i <= 4);
            if (i == 0)      drive(1, 0, 1, 10'd5, 4'b1111, 32'h12345678);
            else if (i == 1) drive(1, 1, 0, 10'd5, 4'b0000, 32'h0);
            else             drive(0, 0, 0, 10'd0, 4'b0000, 32'h0);
            cycle();
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL clken_ctl: valid/wait/done got %b/%b/%b want %b/%b/%b", obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            for (int k = 0; k < 2; k++) begin
                if (obs_valid[k]) begin
                    pulses[k]++;
                    got[k] = obs_data[k];
                end
            end
        end
        clken = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (pulses[k] != 1 || got[k] !== 32'h12345678) begin
                n_fail++;
                $display("FAIL clken_once[%0d]: got %0d pulses data %h want 1 pulse data 12345678", k, pulses[k], got[k]);
            end
        end
    endtask

    task automatic test_reset_req();
        logic [31:0] got [2];
        got = '{32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            reset_req = (i == 1);
            if (i == 0)      drive(1, 0, 1, 10'd7, 4'b1111, 32'hA5A5A5A5);
            else if (i == 1) drive(1, 0, 1, 10'd7, 4'b1111, 32'h5A5A5A5A);
            else if (i == 2) drive(1, 1, 0, 10'd7, 4'b0000, 32'h0);
            else             drive(0, 0, 0, 10'd0, 4'b0000, 32'h0);
            cycle();
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL reset_req_ctl: valid/wait/done got %b/%b/%b want %b/%b/%b", obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            for (int k = 0; k < 2; k++) if (obs_valid[k]) got[k] = obs_data[k];
        end
        reset_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (got[k] !== 32'hA5A5A5A5) begin
                n_fail++;
                $display("FAIL reset_req_blocked[%0d]: got %h want a5a5a5a5", k, got[k]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] seen [2][$];
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       drive(1, 0, 1, 10'd1020, 4'b1111, 32'hCAFEF00D);
                1:       drive(1, 0, 1, 10'd20, 4'b1111, 32'h0BADC0DE);
                2:       drive(1, 1, 0, 10'd1020, 4'b0000, 32'h0);
                3:       drive(1, 1, 0, 10'd20, 4'b0000, 32'h0);
                default: drive(0, 0, 0, 10'd0, 4'b0000, 32'h0);
            endcase
            cycle();
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL oor_ctl: valid/wait/done got %b/%b/%b want %b/%b/%b", obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            for (int k = 0; k < 2; k++) if (obs_valid[k]) seen[k].push_back(obs_data[k]);
        end
        n_tests++;
        if (seen[0].size() != 2 || seen[0][0] !== 32'h0 || seen[0][1] !== 32'h0BADC0DE) begin
            n_fail++;
            $display("FAIL oor_depth1000: got %0d pulses, want 2 pulses 0,0badc0de", seen[0].size());
        end
        n_tests++;
        if (seen[1].size() != 2 || seen[1][0] !== 32'h0 || seen[1][1] !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_depth16: got %0d pulses, want 2 pulses 0,0", seen[1].size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 1, 10'(i), 4'b1111, $urandom);
            cycle();
        end
        for (int i = 0; i < 420; i++) begin
            if (i < 400) begin
                int op;
                op = $urandom_range(0, 2);
                drive($urandom_range(0, 7) != 0, op != 1, op != 0,
                      ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 31)) : 10'(1000 + $urandom_range(0, 23)),
                      4'($urandom), $urandom);
                clken     = $urandom_range(0, 7) != 0;
                reset_req = $urandom_range(0, 9) == 0;
            end else begin
                drive(0, 0, 0, 10'd0, 4'b0000, 32'h0);
                clken = 1'b1; reset_req = 1'b0;
            end
            cycle();
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL random_ctl@%0d: valid/wait/done got %b/%b/%b want %b/%b/%b", i, obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            for (int k = 0; k < 2; k++) begin
                if (dchk[k]) begin
                    n_tests++;
                    if (obs_data[k] !== exp_data[k]) begin
                        n_fail++;
                        $display("FAIL random_data[%0d]@%0d: got %h want %h", k, i, obs_data[k], exp_data[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midread();
        int pulses2;
        pulses2 = 0;
        drive(1, 0, 1, 10'd3, 4'b1111, 32'h76543210);
        cycle();
        drive(1, 1, 0, 10'd3, 4'b0000, 32'h0);
        cycle();
        drive(0, 0, 0, 10'd0, 4'b0000, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 1110; i++) begin
            if (i == 3) reset = 1'b0;
            cycle();
            if (obs_valid[1]) pulses2++;
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL midread_ctl@%0d: valid/wait/done got %b/%b/%b want %b/%b/%b", i, obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            if (i > 3 && obs_done == 2'b11 && exp_done == 2'b11) break;
        end
        n_tests++;
        if (pulses2 != 0) begin
            n_fail++;
            $display("FAIL midread_discard: got %0d pulses want 0", pulses2);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1, 1, 0, 10'd3, 4'b0000, 32'h0);
            else        drive(0, 0, 0, 10'd0, 4'b0000, 32'h0);
            cycle();
            n_tests++;
            if ({obs_valid, obs_wait, obs_done} !== {exp_valid, exp_wait, exp_done}) begin
                n_fail++;
                $display("FAIL post_reset_ctl: valid/wait/done got %b/%b/%b want %b/%b/%b", obs_valid, obs_wait, obs_done, exp_valid, exp_wait, exp_done);
            end
            for (int k = 0; k < 2; k++) begin
                if (dchk[k]) begin
                    n_tests++;
                    if (obs_data[k] !== exp_data[k]) begin
                        n_fail++;
                        $display("FAIL post_reset_data[%0d]: got %h want %h", k, obs_data[k], exp_data[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 1024; a++) mdl[k][a] = '0;
            last_rd[k] = '0;
            rc[k] = 0;
        end
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        drive(0, 0, 0, '0, '0, '0);
        test_reset();
        test_write_bytes();
        test_back_to_back();
        test_clken();
        test_reset_req();
        test_out_of_range();
        test_random();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_onchip_memory_pipelined.md
# nios_onchip_memory_pipelined

Parametrised single-port on-chip RAM exposed as an Avalon-MM pipelined slave on the Nios system interconnect. Extends the fixed 32x1024 on-chip memory with configurable width/depth, selectable read latency (1 or 2), an explicit `readdatavalid`/`waitrequest` handshake, and an optional zero-fill engine that clears the array after reset. Sits between the system interconnect and the inferred block RAM.

## Interface
- `DATA_WIDTH`, 32: data width; multiple of 8, range 8..128.
- `ADDR_WIDTH`, 10: word address width.
- `DEPTH`, 1024: number of words; must satisfy `DEPTH <= 2**ADDR_WIDTH`.
- `READ_LATENCY`, 1: accept-to-`readdatavalid` cycles; legal values are 1 or 2.
- `INIT_FILE`, "nios_onchip_memory2_0.hex": power-up contents.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `address` in ADDR_WIDTH: word address.
- `byteenable` in DATA_WIDTH/8: write byte lanes.
- `chipselect` in 1: slave select.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in DATA_WIDTH: write data.
- `clken` in 1: global clock enable. When low, all state freezes.
- `reset_req` in 1: reset-pending indication. Blocks acceptance of new transactions.
- `waitrequest` out 1: slave busy. A request is not accepted while this is high.
- `readdata` out DATA_WIDTH: read data.
- `readdatavalid` out 1: `readdata` is valid this cycle.
- `init_done` out 1: the array is ready for use.

## Operation
- Acceptance: `acc = chipselect & (read | write) & ~waitrequest & clken & ~reset_req`.
- Write on `acc & write`:
  - Byte lane i is written only if `byteenable[i]`.
  - `read & write` together counts as a write only; no `readdatavalid` is produced.
- Read on `acc & read & ~write`:
  - RAM data is registered internally.
  - With `READ_LATENCY=2`, one further output register is added.
  - Each accepted read yields exactly one `readdatavalid` pulse.
  - Reads are returned in order.
- Back-to-back reads are accepted every cycle (fully pipelined).
- A write followed by a read of the same address on the next cycle returns the new data.
- Out-of-range addresses (`address >= DEPTH`): writes are dropped; reads return 0 with a normal `readdatavalid`.
- `clken=0`: the pipeline, the fill counter and the RAM port hold their state. The output is gated: `readdatavalid = valid_q & clken`, so no pulse is duplicated or lost.
- `waitrequest = reset | ~init_done`.
- State machine: `RESET -> FILL -> READY` when the macro is defined; `RESET -> READY` otherwise.
  - `reset` from any state returns to `RESET`.
  - In-flight reads are discarded: `readdatavalid` is 0 the cycle after `reset` is sampled.

## Timing
- Reset values, in the cycle after `reset` is sampled high:
  - `readdata=0`, `readdatavalid=0`, `init_done=0`, `waitrequest=1`.
  - The pipeline valid bits are cleared.
- Read issued at edge N:
  - `READ_LATENCY=1`: `readdatavalid=1` and data are on the outputs in cycle N+1.
  - `READ_LATENCY=2`: in cycle N+2.
  - Each `clken=0` cycle adds one cycle.
- Write takes effect at the accepting edge.
- `readdata` holds its last value when `readdatavalid=0`; it is 0 only after reset.
- Without the macro: `init_done=1` and `waitrequest=0` in the first cycle after `reset` deasserts.

## Configuration
- `NIOS_ONCHIP_MEM_ZEROFILL_EN` defined:
  - After `reset` deasserts, the FSM enters `FILL`.
  - An ADDR_WIDTH-bit counter writes 0 to addresses 0..DEPTH-1, one per `clken` cycle, with all byte lanes enabled.
  - `init_done` rises the cycle after address DEPTH-1 is written, i.e. DEPTH enabled cycles after reset release.
  - `waitrequest` stays high throughout `FILL`.
  - `reset` during `FILL` restarts the fill from 0.
  - `INIT_FILE` contents are overwritten.
- Macro undefined: no fill logic is built, and the array keeps its `INIT_FILE` contents.

## Test plan
- Reset then idle:
  - No macro: `init_done=1` and `waitrequest=0` 1 cycle after reset release.
  - Macro defined, DEPTH=16: `waitrequest` is high for exactly 16 cycles, and a read of address 5 returns 0.
- Write 0xDEADBEEF to address 3 with `byteenable=4'b1111`, then write 0x000000AA with `byteenable=4'b0001`, then read address 3 -> `readdata=0xDEADBEAA`. Valid appears at N+1 for `READ_LATENCY=1` and at N+2 for `READ_LATENCY=2`.
- 4 back-to-back reads of addresses 0..3 (preloaded with 0x10..0x13) -> 4 consecutive `readdatavalid` pulses carrying 0x10, 0x11, 0x12, 0x13 in order.
- Read accepted, then `clken=0` for 3 cycles -> `readdatavalid` stays low while `clken=0`, then pulses exactly once with the correct data after `clken` returns to 1.
- `reset_req=1` with `chipselect=1`, `write=1` to address 7 -> no write; a later read of address 7 returns the old value.
- With DEPTH=1000: write to address 1020 is dropped and a read of address 1020 returns 0. Assert `reset` during a pending read -> no `readdatavalid` and the fill restarts.
